// File: rtl/uart_prog_pkg.sv
// Purpose : shared types and constants for the UART program loader.
// Latency : n/a (types, constants and a helper function only).
// Backpressure: n/a.
package uart_prog_pkg;

  // Receiver FSM encoding
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Memory-select bit, the MSB of the programming address
  localparam logic MEM_INST = 1'b0;
  localparam logic MEM_DATA = 1'b1;

  // Cycles to wait from start-bit detection to the start-bit mid-point
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Purpose : programming bus from the loader to the instruction ROM / data RAM.
// Latency : n/a (signal bundle); master = loader, slave = memories / observers.
// Backpressure: none; write strobes are fire-and-forget.
// Signals : upg_wen_o one-cycle write strobe, upg_adr_o {mem_sel, word_addr},
//           upg_dat_o write data, upg_done_o image complete, frame_err_o stop-bit error pulse.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 14
);
  logic              upg_wen_o;
  logic [ADDR_W:0]   upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              upg_done_o;
  logic              frame_err_o;

  modport master (
    output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, frame_err_o
  );

  modport slave (
    input upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, frame_err_o
  );
endinterface

// File: rtl/uart_rx_core.sv
// Purpose : 8N1 UART receiver: 2-flop synchronizer, baud counter and RX FSM.
// Latency : byte_valid_o / frame_err_o assert combinationally in the stop-bit sample cycle.
// Backpressure: none; the consumer must take each byte on its one-cycle valid.
// Ports   : clk, rst (sync, active-high), rx_i (async serial in, idle high),
//           byte_valid_o + byte_data_o (good byte), frame_err_o (stop bit sampled low).
module uart_rx_core
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(half_bit(CLKS_PER_BIT) - 1);

  logic              rx_meta_q, rx_sync_q;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizer starts at the idle line level so reset is not seen as a start bit
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        // Re-check the start bit at its mid-point; a high line here was a glitch
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {rx_sync_q, shreg_q[7:1]};  // LSB arrives first
          bit_d   = bit_q + 3'd1;               // wraps to 0 after bit 7
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) byte_valid_o = 1'b1;
          else           frame_err_o  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data_o = shreg_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Purpose : assembles UART bytes into LE 32-bit words and writes them to inst then data memory.
// Latency : write strobe one cycle after the 4th byte's stop-bit sample; done one cycle after last strobe.
// Backpressure: none; a strobe finishes long before the next byte can arrive.
// Ports   : clk, rst (sync, active-high), rx_i (UART in), upg (master: wen/adr/dat/done/frame_err).
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 14,
  parameter int INST_WORDS   = 16384,
  parameter int DATA_WORDS   = 16384
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_i,
  uart_prog_loader_if.master  upg
);

  localparam int TOTAL  = INST_WORDS + DATA_WORDS;
  localparam int WCNT_W = $clog2(TOTAL) + 1;

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_err;

  logic [1:0]        idx_q, idx_d;
  logic [23:0]       buf_q, buf_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W:0]   adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              done_q, done_d;
  logic              done_set;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (frame_err)
  );

  // Word w maps to instruction memory first, then data memory from offset 0
  function automatic logic [ADDR_W:0] word_adr(input logic [WCNT_W-1:0] w);
    logic [31:0] wi;
    wi = 32'(w);
    if (wi < 32'(INST_WORDS)) begin
      return {MEM_INST, wi[ADDR_W-1:0]};
    end
    wi = wi - 32'(INST_WORDS);
    return {MEM_DATA, wi[ADDR_W-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      buf_q  <= '0;
      wcnt_q <= '0;
      wen_q  <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      buf_q  <= buf_d;
      wcnt_q <= wcnt_d;
      wen_q  <= wen_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      done_q <= done_d;
    end
  end

  // Strobe for the last word of the image is in flight this cycle
  assign done_set = wen_q && (wcnt_q == WCNT_W'(TOTAL - 1));

  always_comb begin
    idx_d  = idx_q;
    buf_d  = buf_q;
    wcnt_d = wcnt_q;
    wen_d  = 1'b0;
    adr_d  = adr_q;
    dat_d  = dat_q;
    done_d = done_q;

    if (wen_q) wcnt_d = wcnt_q + WCNT_W'(1);
    if (done_set) done_d = 1'b1;

    // Bytes are dropped once the image is complete, including one coinciding with done rising
    if (byte_valid && !done_q && !done_set) begin
      unique case (idx_q)
        2'd0: buf_d[7:0]   = byte_data;
        2'd1: buf_d[15:8]  = byte_data;
        2'd2: buf_d[23:16] = byte_data;
        default: begin
          wen_d = 1'b1;
          dat_d = {byte_data, buf_q};
          adr_d = word_adr(wcnt_q);
        end
      endcase
      idx_d = idx_q + 2'd1;  // wraps to byte 0 after byte 3
    end
  end

  assign upg.upg_wen_o   = wen_q;
  assign upg.upg_adr_o   = adr_q;
  assign upg.upg_dat_o   = dat_q;
  assign upg.upg_done_o  = done_q;
  assign upg.frame_err_o = frame_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Purpose : scoreboard bench for uart_prog_loader (CLKS_PER_BIT=8, 2 inst + 1 data word).
// Latency : checks strobe one cycle after byte valid, done one cycle after last strobe.
// Backpressure: n/a.
module tb_uart_prog_loader;
  import uart_prog_pkg::*;

  localparam int CPB    = 8;
  localparam int ADDR_W = 14;
  localparam int INST   = 2;
  localparam int DATA   = 1;

  typedef struct {
    logic [ADDR_W:0] adr;
    logic [31:0]     dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_i = 1'b1;

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) upg ();

  uart_prog_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (ADDR_W),
    .INST_WORDS   (INST),
    .DATA_WORDS   (DATA)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rx_i (rx_i),
    .upg  (upg)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   strobes = 0;
  int   fe_cnt = 0;
  int   cyc = 0;
  int   last_strobe_cyc = 0;
  logic prev_wen = 1'b0, prev_bv = 1'b0, prev_done = 1'b0, prev_fe = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each strobe
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      strobes   = 0;
      prev_wen  = 1'b0;
      prev_bv   = 1'b0;
      prev_done = 1'b0;
      prev_fe   = 1'b0;
    end else begin
      if (upg.upg_wen_o) begin
        strobes++;
        last_strobe_cyc = cyc;
        chk("wen_one_cycle", 64'(prev_wen), 64'(1'b0));
        chk("wen_after_byte", 64'(prev_bv), 64'(1'b1));
        chk("sb_nonempty", 64'(exp_q.size() > 0), 64'(1'b1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("adr", 64'(upg.upg_adr_o), 64'(e.adr));
          chk("dat", 64'(upg.upg_dat_o), 64'(e.dat));
        end
      end
      if (upg.frame_err_o) begin
        fe_cnt++;
        chk("fe_one_cycle", 64'(prev_fe), 64'(1'b0));
      end
      if (upg.upg_done_o && !prev_done) begin
        chk("done_latency", 64'(cyc - last_strobe_cyc), 64'(1));
        chk("done_words", 64'(strobes), 64'(INST + DATA));
      end
      prev_wen  = upg.upg_wen_o;
      prev_bv   = dut.u_rx.byte_valid_o;
      prev_done = upg.upg_done_o;
      prev_fe   = upg.frame_err_o;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    rx_i = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_stop);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = ~bad_stop;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic expect_word(input logic [ADDR_W:0] a, input logic [31:0] d);
    exp_t e;
    e.adr = a;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  int fe_base;

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_wen", 64'(upg.upg_wen_o), 64'(0));
    chk("rst_adr", 64'(upg.upg_adr_o), 64'(0));
    chk("rst_dat", 64'(upg.upg_dat_o), 64'(0));
    chk("rst_done", 64'(upg.upg_done_o), 64'(0));
    chk("rst_fe", 64'(upg.frame_err_o), 64'(0));
    repeat (200) @(negedge clk);
    chk("idle_no_strobe", 64'(strobes), 64'(0));

    // Single word assembly
    expect_word(15'h0000, 32'h12345678);
    send_word(32'h12345678);
    repeat (10) @(negedge clk);
    chk("word_drained", 64'(exp_q.size()), 64'(0));
    chk("word_strobes", 64'(strobes), 64'(1));
    chk("word_not_done", 64'(upg.upg_done_o), 64'(0));

    // Framing error leaves byte index alone
    do_reset();
    fe_base = fe_cnt;
    send_byte(8'hAA, 1'b1);
    repeat (10) @(negedge clk);
    chk("fe_pulses", 64'(fe_cnt - fe_base), 64'(1));
    chk("fe_no_strobe", 64'(strobes), 64'(0));
    expect_word(15'h0000, 32'h04030201);
    send_word(32'h04030201);
    repeat (10) @(negedge clk);
    chk("fe_word_drained", 64'(exp_q.size()), 64'(0));

    // Short glitch is rejected
    fe_base = fe_cnt;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (2) @(negedge clk);
    rx_i = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_fe", 64'(fe_cnt - fe_base), 64'(0));
    chk("glitch_no_strobe", 64'(strobes), 64'(1));
    chk("glitch_idle", 64'(dut.u_rx.state_q), 64'(RX_IDLE));
    expect_word(15'h0001, 32'h0BADF00D);
    send_word(32'h0BADF00D);
    repeat (10) @(negedge clk);
    chk("glitch_word_drained", 64'(exp_q.size()), 64'(0));

    // Reset mid-word restarts at word 0, byte 0
    do_reset();
    send_byte(8'hEE, 1'b0);
    send_byte(8'hFF, 1'b0);
    do_reset();
    expect_word(15'h0000, 32'h44332211);
    send_word(32'h44332211);
    repeat (10) @(negedge clk);
    chk("midrst_drained", 64'(exp_q.size()), 64'(0));
    chk("midrst_strobes", 64'(strobes), 64'(1));

    // Full image: 2 instruction words then 1 data word
    do_reset();
    expect_word(15'h0000, 32'hDEADBEEF);
    expect_word(15'h0001, 32'h00000013);
    expect_word(15'h4000, 32'hCAFEF00D);
    send_word(32'hDEADBEEF);
    send_word(32'h00000013);
    send_word(32'hCAFEF00D);
    repeat (10) @(negedge clk);
    chk("img_drained", 64'(exp_q.size()), 64'(0));
    chk("img_strobes", 64'(strobes), 64'(3));
    chk("img_done", 64'(upg.upg_done_o), 64'(1));
    send_word(32'h55667788);
    repeat (10) @(negedge clk);
    chk("post_done_strobes", 64'(strobes), 64'(3));
    chk("post_done_adr", 64'(upg.upg_adr_o), 64'(15'h4000));
    chk("post_done_dat", 64'(upg.upg_dat_o), 64'(32'hCAFEF00D));
    chk("post_done_sticky", 64'(upg.upg_done_o), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
